enemy_march_controller: RTL

//  Sequences the enemy formation march: right sweep, step down, left sweep, step down, until landing.

---
 rtl/enemy_march_controller_pkg.sv | 38 +++
 rtl/frame_tick_gen.sv | 30 +++
 rtl/enemy_march_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/enemy_march_controller_pkg.sv
// Shared constants, state type and helpers for the enemy formation march.
package enemy_march_controller_pkg;

    // Scan coordinate width shared with the video timing and sprite blocks.
    localparam int CORDW   = 10;
    // Formation position width (form_x, enemy_y).
    localparam int POS_W   = 10;
    // Position arithmetic is done one bit wider so +STEP never wraps.
    localparam int CALC_W  = POS_W + 1;
    localparam int ALIVE_W = 6;
    // Divider width: DIV_MIN + 63 fits in 7 bits.
    localparam int DIV_W   = 7;

    // Default march geometry and timing.
    localparam int MARCH_X_MIN      = 16;
    localparam int MARCH_X_MAX      = 560;
    localparam int MARCH_Y_START    = 40;
    localparam int MARCH_Y_LAND     = 400;
    localparam int MARCH_STEP_X     = 4;
    localparam int MARCH_STEP_Y     = 8;
    localparam int MARCH_FRAME_LINE = 490;
    localparam int MARCH_DIV_MIN    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RIGHT,
        ST_DOWN_R,
        ST_LEFT,
        ST_DOWN_L,
        ST_LANDED
    } march_state_t;

    // Zero-extend a position into the wide compare domain.
    function automatic logic [CALC_W-1:0] widen(input logic [POS_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Once-per-frame tick: a registered single-cycle pulse at the first pixel of a
// chosen scan line. Shared by every block that moves sprites in vertical blank.
module frame_tick_gen #(
    parameter int CORDW      = 10,
    parameter int FRAME_LINE = 490
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CORDW-1:0] pixel,
    input  logic [CORDW-1:0] line,
    output logic             tick
);

    localparam logic [CORDW-1:0] LINE_C = CORDW'(FRAME_LINE);

    // Register the line/pixel match; suppressed while the mover is frozen.
    always_ff @(posedge clk) begin
        // NOTE: rst_n is sampled on the clock edge (synchronous reset), so it
        // is deliberately absent from the sensitivity list.
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment, so every register clocked here
            // sees the values from before the edge regardless of statement order.
            tick <= enable && (line == LINE_C) && (pixel == '0);
        end
    end

endmodule

// File: rtl/enemy_march_controller.sv
// Enemy formation march: right sweep, step down, left sweep, step down, until
// the formation lands. Moves once per divided frame tick, inside vblank, and
// speeds up as fewer enemies remain alive.
module enemy_march_controller
    import enemy_march_controller_pkg::*;
#(
    parameter int X_MIN      = MARCH_X_MIN,
    parameter int X_MAX      = MARCH_X_MAX,
    parameter int Y_START    = MARCH_Y_START,
    parameter int Y_LAND     = MARCH_Y_LAND,
    parameter int STEP_X     = MARCH_STEP_X,
    parameter int STEP_Y     = MARCH_STEP_Y,
    parameter int FRAME_LINE = MARCH_FRAME_LINE,
    parameter int DIV_MIN    = MARCH_DIV_MIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CORDW-1:0]   pixel,
    input  logic [CORDW-1:0]   line,
    input  logic               enable,
    input  logic               restart,
    input  logic [ALIVE_W-1:0] alive_cnt,
    output logic [POS_W-1:0]   form_x,
    output logic [POS_W-1:0]   enemy_y,
    output logic               dir_left,
    output logic               step_pulse,
    output logic               landed
);

    localparam logic [CALC_W-1:0] X_MAX_C  = CALC_W'(X_MAX);
    localparam logic [CALC_W-1:0] X_LEFT_C = CALC_W'(X_MIN + STEP_X);
    localparam logic [CALC_W-1:0] STEP_X_C = CALC_W'(STEP_X);
    localparam logic [CALC_W-1:0] STEP_Y_C = CALC_W'(STEP_Y);
    localparam logic [CALC_W-1:0] Y_LAND_C = CALC_W'(Y_LAND);

    logic              tick;
    march_state_t      state;
    logic [DIV_W-1:0]  frame_cnt;
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  period_m1;
    logic              div_hit;
    logic              mv;
    logic [CALC_W-1:0] x_wide;
    logic [CALC_W-1:0] x_inc;
    logic [CALC_W-1:0] x_dec;
    logic [CALC_W-1:0] y_next;

    frame_tick_gen #(
        .CORDW      (CORDW),
        .FRAME_LINE (FRAME_LINE)
    ) u_frame_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .pixel  (pixel),
        .line   (line),
        .tick   (tick)
    );

    // Frames per move shrink with the alive count; an empty wave never moves.
    assign period    = DIV_W'(DIV_MIN) + DIV_W'(alive_cnt);
    assign period_m1 = period - DIV_W'(1);
    assign div_hit   = frame_cnt >= period_m1;
    assign mv        = tick && div_hit && (alive_cnt != '0);

    // Candidate positions, one bit wider so the edge compares cannot wrap.
    assign x_wide = widen(form_x);
    assign x_inc  = x_wide + STEP_X_C;
    assign x_dec  = x_wide - STEP_X_C;
    assign y_next = widen(enemy_y) + STEP_Y_C;

    // March FSM, frame divider and registered outputs; restart mirrors reset.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state      <= ST_IDLE;
            form_x     <= POS_W'(X_MIN);
            enemy_y    <= POS_W'(Y_START);
            dir_left   <= 1'b0;
            step_pulse <= 1'b0;
            landed     <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            // The pulse is an event, not state: it clears even while frozen.
            step_pulse <= 1'b0;
            if (enable) begin
                if (tick) begin
                    frame_cnt <= div_hit ? '0 : frame_cnt + DIV_W'(1);
                end
                case (state)
                    ST_IDLE: begin
                        state <= ST_RIGHT;
                    end
                    ST_RIGHT: begin
                        if (mv) begin
                            if (x_inc <= X_MAX_C) begin
                                form_x     <= x_inc[POS_W-1:0];
                                step_pulse <= 1'b1;
                            end else begin
                                state <= ST_DOWN_R;
                            end
                        end
                    end
                    ST_LEFT: begin
                        if (mv) begin
                            if (x_wide >= X_LEFT_C) begin
                                form_x     <= x_dec[POS_W-1:0];
                                step_pulse <= 1'b1;
                            end else begin
                                state <= ST_DOWN_L;
                            end
                        end
                    end
                    ST_DOWN_R, ST_DOWN_L: begin
                        if (mv) begin
                            enemy_y    <= y_next[POS_W-1:0];
                            step_pulse <= 1'b1;
                            if (y_next >= Y_LAND_C) begin
                                state  <= ST_LANDED;
                                landed <= 1'b1;
                            end else if (state == ST_DOWN_R) begin
                                state    <= ST_LEFT;
                                dir_left <= 1'b1;
                            end else begin
                                state    <= ST_RIGHT;
                                dir_left <= 1'b0;
                            end
                        end
                    end
                    ST_LANDED: begin
                        landed <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
